// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss/refill controller between the 4-way cache and memory.
// Fetches missing lines over a req/ack handshake, forwards hits on the
// one-entry write-back buffer, and drains evicted lines before any fetch.
// Optional watchdog on the memory handshake: define MISS_CTRL_TIMEOUT_EN.
module cache_miss_ctrl #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int LINE_SIZE_BITS = 32,
  parameter int OFFSET_BITS    = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_miss,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
  input  logic                      i_evict,
  input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_evict_data,
  output logic [LINE_SIZE_BITS-1:0] o_memory_line,
  output logic                      o_memory_response,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
  output logic [LINE_SIZE_BITS-1:0] o_mem_wdata,
  input  logic                      i_mem_ack,
  input  logic [LINE_SIZE_BITS-1:0] i_mem_rdata,
  output logic                      o_busy,
  output logic                      o_error
);

  typedef enum logic [1:0] {IDLE, WB_REQ, RD_REQ, RESP} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = {ADDRESS_WIDTH{1'b1}} << OFFSET_BITS;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic                      r_buf_valid;
  logic [ADDRESS_WIDTH-1:0]  r_buf_addr;
  logic [LINE_SIZE_BITS-1:0] r_buf_data;
  logic [ADDRESS_WIDTH-1:0]  r_miss_line;
  logic [LINE_SIZE_BITS-1:0] r_memory_line;
  logic                      r_memory_response;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDRESS_WIDTH-1:0]  r_mem_addr;
  logic [LINE_SIZE_BITS-1:0] r_mem_wdata;
  logic                      r_busy;
  logic                      r_error;

  logic                      w_buf_valid;
  logic [ADDRESS_WIDTH-1:0]  w_buf_addr;
  logic [LINE_SIZE_BITS-1:0] w_buf_data;
  logic [ADDRESS_WIDTH-1:0]  w_miss_line;
  logic [LINE_SIZE_BITS-1:0] w_memory_line;
  logic                      w_memory_response;
  logic                      w_mem_req;
  logic                      w_mem_we;
  logic [ADDRESS_WIDTH-1:0]  w_mem_addr;
  logic [LINE_SIZE_BITS-1:0] w_mem_wdata;
  logic                      w_busy;
  logic                      w_error;
  logic                      w_wb_done;
  logic                      w_timeout;
  logic [ADDRESS_WIDTH-1:0]  w_miss_line_addr;
  logic [ADDRESS_WIDTH-1:0]  w_evict_line_addr;

  assign w_miss_line_addr  = i_miss_addr & LINE_MASK;
  assign w_evict_line_addr = i_evict_addr & LINE_MASK;

`ifdef MISS_CTRL_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] r_timer;

  assign w_timeout = r_mem_req && !i_mem_ack && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts request cycles, restarts whenever the request ends or is acked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!r_mem_req || i_mem_ack || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State and all registered outputs; reset kills any transaction immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= IDLE;
      r_buf_valid       <= 1'b0;
      r_buf_addr        <= '0;
      r_buf_data        <= '0;
      r_miss_line       <= '0;
      r_memory_line     <= '0;
      r_memory_response <= 1'b0;
      r_mem_req         <= 1'b0;
      r_mem_we          <= 1'b0;
      r_mem_addr        <= '0;
      r_mem_wdata       <= '0;
      r_busy            <= 1'b0;
      r_error           <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_buf_valid       <= w_buf_valid;
      r_buf_addr        <= w_buf_addr;
      r_buf_data        <= w_buf_data;
      r_miss_line       <= w_miss_line;
      r_memory_line     <= w_memory_line;
      r_memory_response <= w_memory_response;
      r_mem_req         <= w_mem_req;
      r_mem_we          <= w_mem_we;
      r_mem_addr        <= w_mem_addr;
      r_mem_wdata       <= w_mem_wdata;
      r_busy            <= w_busy;
      r_error           <= w_error;
    end
  end

  // Next state, buffer bookkeeping and next output values (outputs follow next state)
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_valid   = r_buf_valid;
    w_buf_addr    = r_buf_addr;
    w_buf_data    = r_buf_data;
    w_miss_line   = r_miss_line;
    w_memory_line = r_memory_line;
    w_error       = r_error;
    w_wb_done     = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_miss && r_buf_valid && (w_miss_line_addr == r_buf_addr)) begin
          w_memory_line = r_buf_data;
          w_state_nxt   = RESP;
        end else if (r_buf_valid) begin
          w_state_nxt   = WB_REQ;
        end else if (i_miss) begin
          w_miss_line   = w_miss_line_addr;
          w_state_nxt   = RD_REQ;
        end
      end
      WB_REQ: begin
        if (i_mem_ack) begin
          w_wb_done   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_timeout) begin
          w_wb_done   = 1'b1;
          w_error     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RD_REQ: begin
        if (i_mem_ack) begin
          w_memory_line = i_mem_rdata;
          w_state_nxt   = RESP;
        end else if (w_timeout) begin
          w_memory_line = '0;
          w_error       = 1'b1;
          w_state_nxt   = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (i_evict) begin
      if (!r_buf_valid || w_wb_done) begin
        w_buf_valid = 1'b1;
        w_buf_addr  = w_evict_line_addr;
        w_buf_data  = i_evict_data;
      end else begin
        w_error     = 1'b1;
      end
    end else if (w_wb_done) begin
      w_buf_valid = 1'b0;
    end

    w_mem_req         = (w_state_nxt == WB_REQ) || (w_state_nxt == RD_REQ);
    w_mem_we          = (w_state_nxt == WB_REQ);
    w_mem_addr        = '0;
    w_mem_wdata       = '0;
    if (w_state_nxt == WB_REQ) begin
      w_mem_addr  = r_buf_addr;
      w_mem_wdata = r_buf_data;
    end else if (w_state_nxt == RD_REQ) begin
      w_mem_addr  = w_miss_line;
    end
    w_memory_response = (w_state_nxt == RESP);
    w_busy            = (w_state_nxt != IDLE) || w_buf_valid;
  end

  assign o_memory_line     = r_memory_line;
  assign o_memory_response = r_memory_response;
  assign o_mem_req         = r_mem_req;
  assign o_mem_we          = r_mem_we;
  assign o_mem_addr        = r_mem_addr;
  assign o_mem_wdata       = r_mem_wdata;
  assign o_busy            = r_busy;
  assign o_error           = r_error;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed tests for cache_miss_ctrl with a transaction-level
// reference model checked every cycle. Define MISS_CTRL_TIMEOUT_EN to add the watchdog test.
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [31:0] i_miss_addr;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_error;

  int vectors     = 0;
  int miscompares = 0;

  bit          mBufValid;
  logic [31:0] mBufAddr;
  logic [31:0] mBufData;
  logic [31:0] mExpLine;
  bit          mError;
  int          mReqRun;

  cache_miss_ctrl #(
    .ADDRESS_WIDTH(32), .LINE_SIZE_BITS(32), .OFFSET_BITS(6), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_evict(i_evict), .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
    .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lineOf(input logic [31:0] a);
    return a & 32'hFFFF_FFC0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic miss, input logic [31:0] mAddr,
                               input logic ev, input logic [31:0] eAddr, input logic [31:0] eData,
                               input logic ack, input logic [31:0] rdata);
    i_miss       = miss;
    i_miss_addr  = mAddr;
    i_evict      = ev;
    i_evict_addr = eAddr;
    i_evict_data = eData;
    i_mem_ack    = ack;
    i_mem_rdata  = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: checks outputs mid-cycle, then folds in what the coming edge will sample
  always @(negedge clk) begin
    bit wbAck, rdAck, idle, drained;
    if (rst) begin
      mBufValid = 0; mBufAddr = '0; mBufData = '0; mExpLine = '0; mError = 0; mReqRun = 0;
    end else begin
      checkOutput("error", {31'b0, o_error}, {31'b0, mError});
      checkOutput("busy", {31'b0, o_busy}, {31'b0, mBufValid || o_mem_req || o_memory_response});
      if (o_mem_req && o_mem_we) begin
        checkOutput("wbBufValid", {31'b0, o_mem_req}, {31'b0, mBufValid});
        checkOutput("wbAddr", o_mem_addr, mBufAddr);
        checkOutput("wbData", o_mem_wdata, mBufData);
      end
      if (o_mem_req && !o_mem_we) checkOutput("rdAddr", o_mem_addr, lineOf(i_miss_addr));
      if (o_memory_response) checkOutput("respLine", o_memory_line, mExpLine);

      wbAck   = o_mem_req && o_mem_we && i_mem_ack;
      rdAck   = o_mem_req && !o_mem_we && i_mem_ack;
      idle    = !o_mem_req && !o_memory_response;
      drained = wbAck;
      if (idle && i_miss && mBufValid && lineOf(i_miss_addr) == mBufAddr) mExpLine = mBufData;
      if (rdAck) mExpLine = i_mem_rdata;
`ifdef MISS_CTRL_TIMEOUT_EN
      if (o_mem_req && !i_mem_ack) begin
        mReqRun++;
        if (mReqRun == 16) begin
          mError = 1;
          if (o_mem_we) drained = 1;
          else mExpLine = '0;
          mReqRun = 0;
        end
      end else begin
        mReqRun = 0;
      end
`endif
      if (i_evict) begin
        if (!mBufValid || drained) begin
          mBufValid = 1; mBufAddr = lineOf(i_evict_addr); mBufData = i_evict_data;
        end else begin
          mError = 1;
        end
      end else if (drained) begin
        mBufValid = 0;
      end
    end
  end

  // Bounded run: never hang on a stuck handshake
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    checkOutput("rstReq",  {31'b0, o_mem_req}, 32'd0);
    checkOutput("rstResp", {31'b0, o_memory_response}, 32'd0);
    checkOutput("rstBusy", {31'b0, o_busy}, 32'd0);
    checkOutput("rstErr",  {31'b0, o_error}, 32'd0);
    tick();

    $display("[TB] test 1: clean miss");
    applyStimulus(1, 32'h0000_1234, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t1Req",  {31'b0, o_mem_req}, 32'd1);
    checkOutput("t1We",   {31'b0, o_mem_we}, 32'd0);
    checkOutput("t1Addr", o_mem_addr, 32'h0000_1200);
    tick(); tick(); tick();
    checkOutput("t1Hold", {31'b0, o_mem_req}, 32'd1);
    applyStimulus(1, 32'h0000_1234, 0, 0, 0, 1, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1, 32'h0000_1234, 0, 0, 0, 0, 0);
    checkOutput("t1Resp",   {31'b0, o_memory_response}, 32'd1);
    checkOutput("t1Line",   o_memory_line, 32'hDEAD_BEEF);
    checkOutput("t1ReqOff", {31'b0, o_mem_req}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1Pulse", {31'b0, o_memory_response}, 32'd0);
    tick(); tick(); tick();
    checkOutput("t1NoRetrig", {31'b0, o_mem_req}, 32'd0);
    checkOutput("t1Idle",     {31'b0, o_busy}, 32'd0);

    $display("[TB] test 2: evict then miss");
    applyStimulus(0, 0, 1, 32'h0000_4000, 32'h1122_3344, 0, 0);
    tick();
    applyStimulus(1, 32'h0000_8000, 0, 0, 0, 0, 0);
    checkOutput("t2Busy", {31'b0, o_busy}, 32'd1);
    tick();
    checkOutput("t2WbReq",  {31'b0, o_mem_req}, 32'd1);
    checkOutput("t2WbWe",   {31'b0, o_mem_we}, 32'd1);
    checkOutput("t2WbAddr", o_mem_addr, 32'h0000_4000);
    checkOutput("t2WbData", o_mem_wdata, 32'h1122_3344);
    applyStimulus(1, 32'h0000_8000, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 32'h0000_8000, 0, 0, 0, 0, 0);
    checkOutput("t2Gap", {31'b0, o_mem_req}, 32'd0);
    tick();
    checkOutput("t2RdReq",  {31'b0, o_mem_req}, 32'd1);
    checkOutput("t2RdWe",   {31'b0, o_mem_we}, 32'd0);
    checkOutput("t2RdAddr", o_mem_addr, 32'h0000_8000);
    applyStimulus(1, 32'h0000_8000, 0, 0, 0, 1, 32'h55AA_55AA);
    tick();
    applyStimulus(1, 32'h0000_8000, 0, 0, 0, 0, 0);
    checkOutput("t2Resp", {31'b0, o_memory_response}, 32'd1);
    checkOutput("t2Line", o_memory_line, 32'h55AA_55AA);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("[TB] test 3: forward hit");
    applyStimulus(0, 0, 1, 32'h0000_4000, 32'hCAFE_F00D, 0, 0);
    tick();
    applyStimulus(1, 32'h0000_4010, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t3Resp", {31'b0, o_memory_response}, 32'd1);
    checkOutput("t3Line", o_memory_line, 32'hCAFE_F00D);
    checkOutput("t3NoRd", {31'b0, o_mem_req}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t3Gap",  {31'b0, o_mem_req}, 32'd0);
    checkOutput("t3Busy", {31'b0, o_busy}, 32'd1);
    tick();
    checkOutput("t3WbReq",  {31'b0, o_mem_req}, 32'd1);
    checkOutput("t3WbWe",   {31'b0, o_mem_we}, 32'd1);
    checkOutput("t3WbAddr", o_mem_addr, 32'h0000_4000);
    checkOutput("t3WbData", o_mem_wdata, 32'hCAFE_F00D);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3Done", {31'b0, o_busy}, 32'd0);
    tick();

    $display("[TB] test 4: buffer overflow");
    applyStimulus(0, 0, 1, 32'h0000_2000, 32'hAAAA_0001, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_3000, 32'hBBBB_0002, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4Err",    {31'b0, o_error}, 32'd1);
    checkOutput("t4WbAddr", o_mem_addr, 32'h0000_2000);
    checkOutput("t4WbData", o_mem_wdata, 32'hAAAA_0001);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t4Sticky", {31'b0, o_error}, 32'd1);
    checkOutput("t4Empty",  {31'b0, o_busy}, 32'd0);

    $display("[TB] test 5: reset mid-read");
    applyStimulus(1, 32'h0000_7777, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t5Req",  {31'b0, o_mem_req}, 32'd1);
    checkOutput("t5Addr", o_mem_addr, 32'h0000_7740);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5AsyncReq", {31'b0, o_mem_req}, 32'd0);
    checkOutput("t5Busy",     {31'b0, o_busy}, 32'd0);
    checkOutput("t5Err",      {31'b0, o_error}, 32'd0);
    checkOutput("t5Addr0",    o_mem_addr, 32'd0);
    checkOutput("t5Line0",    o_memory_line, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    applyStimulus(1, 32'h0000_9ABC, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t5FreshReq",  {31'b0, o_mem_req}, 32'd1);
    checkOutput("t5FreshAddr", o_mem_addr, 32'h0000_9A80);
    applyStimulus(1, 32'h0000_9ABC, 0, 0, 0, 1, 32'h0BAD_CAFE);
    tick();
    applyStimulus(1, 32'h0000_9ABC, 0, 0, 0, 0, 0);
    checkOutput("t5Resp", {31'b0, o_memory_response}, 32'd1);
    checkOutput("t5Line", o_memory_line, 32'h0BAD_CAFE);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] test 7: evict during write-back ack");
    applyStimulus(0, 0, 1, 32'h0000_5000, 32'hC0C0_C0C0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t7WbAddr", o_mem_addr, 32'h0000_5000);
    applyStimulus(0, 0, 1, 32'h0000_6000, 32'h6666_6666, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t7NoErr", {31'b0, o_error}, 32'd0);
    checkOutput("t7Busy",  {31'b0, o_busy}, 32'd1);
    tick();
    checkOutput("t7Wb2Addr", o_mem_addr, 32'h0000_6000);
    checkOutput("t7Wb2Data", o_mem_wdata, 32'h6666_6666);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t7Done", {31'b0, o_busy}, 32'd0);
    tick();

`ifdef MISS_CTRL_TIMEOUT_EN
    begin
      int n;
      $display("[TB] test 6: read timeout");
      applyStimulus(1, 32'h0000_1000, 0, 0, 0, 0, 0);
      tick();
      n = 0;
      while (o_mem_req && n < 100) begin
        n++;
        tick();
      end
      checkOutput("t6ReqCycles", n, 32'd16);
      checkOutput("t6Resp", {31'b0, o_memory_response}, 32'd1);
      checkOutput("t6Line", o_memory_line, 32'd0);
      checkOutput("t6Err",  {31'b0, o_error}, 32'd1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
